// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares the single-port instruction/data block RAM of the riscv core
//   between the fetch requester and the load/store requester. Only one
//   transaction is in flight at a time. Data requests win ties. Once
//   STARVE_LIMIT consecutive data grants have gone by while fetch was
//   waiting, fetch is served first.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   if_req_*          fetch request: valid/addr in, ready out
//   if_rsp_*          fetch response: one-cycle valid pulse and held data
//   d_req_*           load/store request: valid/we/be/addr/wdata in, ready out
//   d_rsp_*           load/store response: one-cycle valid pulse, read data
//                     (0 on a write acknowledge)
//   mem_*             RAM port: en/we/addr/wdata registered out, rdata in
//   busy              high whenever a transaction occupies the arbiter
//
// Timing, with the request accepted on edge T:
//   T+1               ISSUE: mem_en pulse
//   T+2..T+1+LAT      WAIT (reads only): rdata captured on the last cycle
//   T+2 (write) or T+2+LAT (read)    RESP: rsp_valid pulse, then IDLE
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,

  input  logic                  d_req_valid,
  input  logic                  d_req_we,
  input  logic [DATA_W/8-1:0]   d_req_be,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W-1:0]     d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_rdata,

  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LAT_W = 3;
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  // Reject configurations the datapath cannot represent.
  generate
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("riscv_mem_arbiter: DATA_W must be a multiple of 8");
    end
    if ((MEM_LATENCY == 0) || (MEM_LATENCY > 4)) begin : g_bad_latency
      $error("riscv_mem_arbiter: MEM_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               sel_if_q, sel_if_d;   // granted requester is fetch
  logic               we_q, we_d;           // granted request is a write

  logic               mem_en_d;
  logic [BE_W-1:0]    mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;
  logic               if_rsp_valid_d;
  logic [DATA_W-1:0]  if_rsp_data_d;
  logic               d_rsp_valid_d;
  logic [DATA_W-1:0]  d_rsp_rdata_d;
  logic               busy_d;

  logic               force_if;
  logic               if_grant;
  logic               d_grant;

  // Request readies; held low during reset so nothing is accepted then.
  always_comb begin
    force_if     = (starve_q == CNT_W'(STARVE_LIMIT));
    d_req_ready  = !rst && (state_q == IDLE) && !(force_if && if_req_valid);
    if_req_ready = !rst && (state_q == IDLE) && (!d_req_valid || force_if);
    if_grant     = if_req_valid && if_req_ready;
    d_grant      = d_req_valid && d_req_ready;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    lat_d          = lat_q;
    sel_if_d       = sel_if_q;
    we_d           = we_q;
    mem_en_d       = 1'b0;
    mem_we_d       = '0;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data;
    d_rsp_valid_d  = 1'b0;
    d_rsp_rdata_d  = d_rsp_rdata;

    unique case (state_q)
      IDLE: begin
        // The mem_* registers double as the request latch: they are loaded
        // on accept so the ISSUE cycle drives them straight to the RAM.
        if (if_grant) begin
          sel_if_d   = 1'b1;
          we_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = if_req_addr;
          starve_d   = '0;
          state_d    = ISSUE;
        end else if (d_grant) begin
          sel_if_d    = 1'b0;
          we_d        = d_req_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_req_we ? d_req_be : '0;
          mem_addr_d  = d_req_addr;
          mem_wdata_d = d_req_wdata;
          state_d     = ISSUE;
          // Count data grants that overtook a waiting fetch.
          if (if_req_valid) begin
            if (!force_if) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end else begin
            starve_d = '0;
          end
        end
      end

      ISSUE: begin
        if (we_q) begin
          // Writes are acknowledged right away; only data can write.
          d_rsp_valid_d = 1'b1;
          d_rsp_rdata_d = '0;
          state_d       = RESP;
        end else begin
          lat_d   = LAT_W'(MEM_LATENCY);
          state_d = WAIT;
        end
      end

      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        // Last wait cycle: RAM data is valid now.
        if (lat_q <= LAT_W'(1)) begin
          state_d = RESP;
          if (sel_if_q) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rdata;
          end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_rdata_d = mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      lat_q        <= '0;
      sel_if_q     <= 1'b0;
      we_q         <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_rdata  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      sel_if_q     <= sel_if_d;
      we_q         <= we_d;
      mem_en       <= mem_en_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      if_rsp_valid <= if_rsp_valid_d;
      if_rsp_data  <= if_rsp_data_d;
      d_rsp_valid  <= d_rsp_valid_d;
      d_rsp_rdata  <= d_rsp_rdata_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: directed scenarios plus random traffic.
// Requester queues feed a driver; a negedge monitor predicts readies, busy,
// RAM strobes and responses from a shadow memory and scores the DUT.
module tb_riscv_mem_arbiter;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned LAT = 3;
  localparam int          LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic           if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0]  if_req_addr;
  logic [DW-1:0]  if_rsp_data;
  logic           d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [BW-1:0]  d_req_be;
  logic [AW-1:0]  d_req_addr;
  logic [DW-1:0]  d_req_wdata, d_rsp_rdata;
  logic           mem_en, busy;
  logic [BW-1:0]  mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;

  riscv_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_be(d_req_be),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
    end
  endtask

  // Power-on RAM contents, shared by the RAM model and the shadow copy.
  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 'h010) return 32'h00500093;
    if (a == 'h005) return 32'hCAFEF00D;
    if (a >= 'h20 && a < 'h40) return '0;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- RAM model: fixed read latency of LAT cycles ----------
  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:LAT-1];
  bit            ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(i);
      ram_loaded = 1'b1;
    end
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    if (mem_en) begin
      pipe[0] <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end else begin
      pipe[0] <= 32'hBAD0BAD0;
    end
  end
  assign mem_rdata = pipe[LAT-1];

  // ---------------- requester queues and driver ---------------------------
  typedef struct {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic [AW-1:0] if_pend[$];
  dreq_t         d_pend[$];
  bit            if_hs = 1'b0;
  bit            d_hs  = 1'b0;

  initial begin
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = '0; d_req_addr = '0; d_req_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (if_hs && if_pend.size() > 0) void'(if_pend.pop_front());
      if (d_hs && d_pend.size() > 0) void'(d_pend.pop_front());
      if_req_valid = !rst && (if_pend.size() > 0);
      if (if_pend.size() > 0) if_req_addr = if_pend[0];
      d_req_valid = !rst && (d_pend.size() > 0);
      if (d_pend.size() > 0) begin
        d_req_we    = d_pend[0].we;
        d_req_be    = d_pend[0].be;
        d_req_addr  = d_pend[0].addr;
        d_req_wdata = d_pend[0].wdata;
      end
    end
  end

  // ---------------- reference model and scoreboard ------------------------
  typedef struct { bit is_if; logic [DW-1:0] data; int due; } rsp_t;
  typedef struct { int due; logic [AW-1:0] addr; logic [BW-1:0] we; logic [DW-1:0] wdata; } mem_t;

  rsp_t          exp_rsp[$];
  mem_t          exp_mem[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            sh_loaded = 1'b0;
  int            next_free = 0;   // first cycle the arbiter is idle again
  int            streak = 0;      // data grants that overtook a waiting fetch
  string         glog = "";
  logic [DW-1:0] last_if_data = '0;
  logic [DW-1:0] last_d_data = '0;

  always @(negedge clk) begin : monitor
    rsp_t          e;
    mem_t          m;
    bit            idle, exp_dr, exp_ir;
    logic [DW-1:0] nw;
    if (!sh_loaded) begin
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
      sh_loaded = 1'b1;
    end
    if_hs = 1'b0;
    d_hs  = 1'b0;
    if (rst) begin
      exp_rsp.delete();
      exp_mem.delete();
      next_free = 0;
      streak = 0;
    end else begin
      idle   = (cyc >= next_free);
      exp_dr = idle && !(streak == LIM && if_req_valid);
      exp_ir = idle && (!d_req_valid || streak == LIM);
      check("busy", 64'(busy), 64'(!idle));
      check("d_req_ready", 64'(d_req_ready), 64'(exp_dr));
      check("if_req_ready", 64'(if_req_ready), 64'(exp_ir));

      // RAM strobe
      if (exp_mem.size() > 0 && exp_mem[0].due < cyc) begin
        void'(exp_mem.pop_front());
        check("mem_en_missing", 64'(0), 64'(1));
      end
      if (mem_en) begin
        if (exp_mem.size() == 0) check("mem_en_spurious", 64'(1), 64'(0));
        else begin
          m = exp_mem.pop_front();
          check("mem_en_cycle", 64'(cyc), 64'(m.due));
          check("mem_addr", 64'(mem_addr), 64'(m.addr));
          check("mem_we", 64'(mem_we), 64'(m.we));
          if (m.we != '0) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
        end
      end else begin
        check("mem_we_idle", 64'(mem_we), 64'(0));
      end

      // Responses
      if (if_rsp_valid) last_if_data = if_rsp_data;
      if (d_rsp_valid) last_d_data = d_rsp_rdata;
      if (exp_rsp.size() > 0 && exp_rsp[0].due < cyc) begin
        void'(exp_rsp.pop_front());
        check("rsp_missing", 64'(0), 64'(1));
      end
      if (if_rsp_valid || d_rsp_valid) begin
        if (exp_rsp.size() == 0) check("rsp_spurious", 64'(1), 64'(0));
        else begin
          e = exp_rsp.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(e.due));
          check("rsp_if_valid", 64'(if_rsp_valid), 64'(e.is_if));
          check("rsp_d_valid", 64'(d_rsp_valid), 64'(!e.is_if));
          check("rsp_data", 64'(e.is_if ? if_rsp_data : d_rsp_rdata), 64'(e.data));
        end
      end

      // Handshakes: predict the whole transaction from this accept.
      if_hs = if_req_valid && if_req_ready;
      d_hs  = d_req_valid && d_req_ready;
      if (if_hs && d_hs) begin
        check("double_grant", 64'(1), 64'(0));
      end else if (if_hs) begin
        exp_mem.push_back('{due: cyc + 1, addr: if_req_addr, we: '0, wdata: '0});
        exp_rsp.push_back('{is_if: 1'b1, data: shadow[if_req_addr], due: cyc + LAT + 2});
        next_free = cyc + LAT + 3;
        streak = 0;
        glog = {glog, "I"};
      end else if (d_hs) begin
        exp_mem.push_back('{due: cyc + 1, addr: d_req_addr,
                            we: d_req_we ? d_req_be : '0, wdata: d_req_wdata});
        if (d_req_we) begin
          nw = shadow[d_req_addr];
          for (int b = 0; b < BW; b++)
            if (d_req_be[b]) nw[b*8 +: 8] = d_req_wdata[b*8 +: 8];
          shadow[d_req_addr] = nw;
          exp_rsp.push_back('{is_if: 1'b0, data: '0, due: cyc + 2});
          next_free = cyc + 3;
        end else begin
          exp_rsp.push_back('{is_if: 1'b0, data: shadow[d_req_addr], due: cyc + LAT + 2});
          next_free = cyc + LAT + 3;
        end
        streak = if_req_valid ? ((streak < LIM) ? streak + 1 : LIM) : 0;
        glog = {glog, "D"};
      end
    end
  end

  // Wait until every queued request has been served and answered.
  task automatic wait_drain(input int budget);
    int n = 0;
    while ((if_pend.size() > 0 || d_pend.size() > 0 || exp_rsp.size() > 0 || busy)
           && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= budget) check("drain_timeout", 64'(1), 64'(0));
  endtask

  // ---------------- test sequence -----------------------------------------
  initial begin
    int n;
    repeat (3) begin @(negedge clk); #2; end
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'(0));
    check("rst_if_rsp_data", 64'(if_rsp_data), 64'(0));
    check("rst_d_rsp_valid", 64'(d_rsp_valid), 64'(0));
    check("rst_d_rsp_rdata", 64'(d_rsp_rdata), 64'(0));
    check("rst_if_req_ready", 64'(if_req_ready), 64'(0));
    check("rst_d_req_ready", 64'(d_req_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk); #2;

    // Single fetch of a preset instruction word.
    if_pend.push_back(10'h010);
    wait_drain(100);
    check("fetch_0x010", 64'(last_if_data), 64'(32'h00500093));

    // Partial write then read-back.
    d_pend.push_back('{we: 1'b1, be: 4'b0011, addr: 10'h020, wdata: 32'hDEADBEEF});
    d_pend.push_back('{we: 1'b0, be: 4'b0000, addr: 10'h020, wdata: 32'h0});
    wait_drain(100);
    check("readback_0x020", 64'(last_d_data), 64'(32'h0000BEEF));

    // Write with no byte enables leaves memory untouched.
    d_pend.push_back('{we: 1'b1, be: 4'b0000, addr: 10'h021, wdata: 32'hFFFFFFFF});
    d_pend.push_back('{we: 1'b0, be: 4'b0000, addr: 10'h021, wdata: 32'h0});
    wait_drain(100);
    check("readback_be0", 64'(last_d_data), 64'(32'h0));

    // Latency-3 data read of a preset word.
    d_pend.push_back('{we: 1'b0, be: 4'b1111, addr: 10'h005, wdata: 32'h0});
    wait_drain(100);
    check("read_0x005", 64'(last_d_data), 64'(32'hCAFEF00D));

    // Simultaneous requests: data first, then fetch.
    glog = "";
    if_pend.push_back(10'h011);
    d_pend.push_back('{we: 1'b0, be: 4'b0000, addr: 10'h012, wdata: 32'h0});
    wait_drain(100);
    check_str("tie_order", glog, "DI");

    // Starvation guard with fetch held valid throughout.
    glog = "";
    for (int i = 0; i < 8; i++)
      d_pend.push_back('{we: 1'b0, be: 4'b0000, addr: AW'(10'h030 + i), wdata: 32'h0});
    if_pend.push_back(10'h040);
    if_pend.push_back(10'h041);
    wait_drain(400);
    check_str("starve_order", glog, "DDDDIDDDDI");

    // Reset while a read sits in WAIT: the response must be dropped.
    d_pend.push_back('{we: 1'b0, be: 4'b0000, addr: 10'h033, wdata: 32'h0});
    n = 0;
    while (!d_hs && n < 50) begin @(negedge clk); #2; n++; end
    check("reset_test_grant", 64'(d_hs), 64'(1));
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_mem_en", 64'(mem_en), 64'(0));
    check("midrst_d_rsp_valid", 64'(d_rsp_valid), 64'(0));
    @(negedge clk); #2;
    check("midrst_d_rsp_valid2", 64'(d_rsp_valid), 64'(0));
    rst = 1'b0;
    if_pend.push_back(10'h010);
    @(negedge clk); #2;
    check("post_reset_fetch_accept", 64'(if_hs), 64'(1));
    wait_drain(100);
    check("post_reset_fetch_data", 64'(last_if_data), 64'(32'h00500093));

    // Random mixed traffic.
    repeat (600) begin
      dreq_t r;
      @(negedge clk); #2;
      if ($urandom_range(0, 3) == 0 && if_pend.size() < 2)
        if_pend.push_back(AW'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0 && d_pend.size() < 2) begin
        r.we    = 1'($urandom_range(0, 1));
        r.be    = BW'($urandom_range(0, 15));
        r.addr  = AW'($urandom_range(0, 63));
        r.wdata = $urandom;
        d_pend.push_back(r);
      end
    end
    wait_drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Arbitrates the single-port instruction/data RAM of the riscv core between the instruction-fetch requester and the load/store requester. One transaction is in flight at a time. Data accesses have priority, with a starvation guard for fetch. Sits between the core's fetch/LSU stages and the block RAM; all RAM-side outputs are registered.

Parameters:
ADDR_W, 10, word address width (shared by both requesters and the RAM)
DATA_W, 32, data width; must be a multiple of 8
MEM_LATENCY, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4
STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting before fetch is forced first

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_W  fetch word address
if_req_ready  out  1  fetch request accepted this cycle when high with valid
if_rsp_valid  out  1  one-cycle pulse: fetch data valid
if_rsp_data  out  DATA_W  fetched instruction word
d_req_valid  in  1  data request
d_req_we  in  1  1 = write, 0 = read
d_req_be  in  DATA_W/8  byte enables for writes
d_req_addr  in  ADDR_W  data word address
d_req_wdata  in  DATA_W  write data
d_req_ready  out  1  data request accepted when high with valid
d_rsp_valid  out  1  one-cycle pulse: read data valid or write acknowledged
d_rsp_rdata  out  DATA_W  read data; 0 on write ack
mem_en  out  1  RAM access strobe
mem_we  out  DATA_W/8  RAM byte write enables
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, starve_cnt=0, all outputs 0 (including ready, rsp_valid, mem_*, rsp data).
- States: IDLE, ISSUE, WAIT, RESP.
- Readies are combinational from state and valids:
  - d_req_ready = (state==IDLE) && !(force_if && if_req_valid)
  - if_req_ready = (state==IDLE) && (!d_req_valid || force_if)
  - force_if = (starve_cnt == STARVE_LIMIT)
- At most one handshake per cycle. Accepting a request (edge T) latches requester id, addr, we, be, and wdata, then moves to ISSUE.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on a data grant while if_req_valid is high.
  - Cleared on any fetch grant, and on any data grant while if_req_valid is low.
- ISSUE (cycle T+1): mem_en=1, mem_addr/mem_wdata from latch; mem_we = be if write, else 0.
  - Write: next state RESP.
  - Read: next state WAIT with latency counter = MEM_LATENCY.
- mem_en is high only in ISSUE and is exactly one cycle long; mem_* hold their last value when mem_en is low (mem_we forced to 0).
- WAIT: counter decrements each cycle. When mem_rdata is valid (cycle T+1+MEM_LATENCY), capture it into the response register and move to RESP.
- RESP (read: T+2+MEM_LATENCY; write: T+2):
  - The granted requester's rsp_valid pulses high for exactly one cycle; the other requester's stays 0.
  - Next state IDLE.
  - The response is held in rsp_data until the next response.
- No response back-pressure: requesters must take the response in the pulse cycle.
- Minimum request-to-request spacing: read MEM_LATENCY+3 cycles, write 3 cycles.
- Write with be=0: still runs ISSUE with mem_en=1, mem_we=0; acknowledged like a normal write.
- Requests asserted outside IDLE are ignored (ready=0). Requesters hold valid and payload until ready.
- Reset mid-operation (any state): return to IDLE next cycle, in-flight response dropped (no rsp_valid), starve_cnt=0, mem_en=0.
- DATA_W not a multiple of 8, or MEM_LATENCY outside 1..4: elaboration error.

Test Plan:
- Fetch read, MEM_LATENCY=1, RAM[0x010]=0x00500093. Assert if_req_valid with addr 0x010 at accept edge T.
  → mem_en=1, mem_addr=0x010, mem_we=0 at T+1; if_rsp_valid=1 with data 0x00500093 at T+3 only; d_rsp_valid stays 0.
- Data write: we=1, be=0b0011, addr 0x020, wdata 0xDEADBEEF.
  → mem_we=0b0011 at T+1; d_rsp_valid pulse at T+2 with rdata 0. A following read of 0x020 returns 0x0000BEEF (RAM preset to 0).
- Simultaneous fetch and data valid in IDLE.
  → data granted first (d_req_ready=1, if_req_ready=0); fetch granted on the next IDLE cycle.
- Continuous data reads with fetch valid throughout, STARVE_LIMIT=4.
  → exactly 4 data grants, then 1 fetch grant, then starve_cnt=0 and data resumes.
- Reset asserted in WAIT.
  → next cycle state=IDLE, busy=0, no rsp_valid pulse for the aborted read; a new fetch is accepted the cycle after rst drops.
- MEM_LATENCY=3 read of preset word 0xCAFEF00D.
  → rsp_valid exactly at T+5 with 0xCAFEF00D; busy high from T+1 through T+5.
